// File: rtl/k005297_sumcmp_gen.sv
// k005297_sumcmp_gen: bit-serial ADD/XOR page checksum accumulator with serial reference compare.
// The accumulator is a circular shift register; in user-page mode only acc[SUM_W-1:USER_TAP]
// forms the effective register, and the bits below USER_TAP carry no meaning.
module k005297_sumcmp_gen #(
    parameter int SUM_W    = 12,
    parameter int USER_TAP = 4
) (
    input  logic                     i_MCLK,
    input  logic                     i_RST_n,
    input  logic                     i_CLK2M_PCEN_n,
    input  logic                     i_START,
    input  logic                     i_MODE,
    input  logic                     i_LEN_SEL,
    input  logic                     i_BIT_VLD,
    input  logic                     i_BIT,
    input  logic                     i_CARRY_CLR,
    input  logic                     i_REF_LD,
    input  logic [SUM_W-1:0]         i_REF,
    input  logic                     i_CHECK,
    output logic                     o_BUSY,
    output logic                     o_DONE,
    output logic                     o_SUMEQ_n,
    output logic [SUM_W-1:0]         o_SUM,
    output logic [$clog2(SUM_W)-1:0] o_MISMATCH_POS
);
    localparam int CW     = $clog2(SUM_W);
    localparam int L_USER = SUM_W - USER_TAP;

    typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d, ref_q, ref_d;
    logic             carry_q, carry_d, len_q, len_d, miss_q, miss_d, sumeq_n_q, sumeq_n_d;
    logic [CW-1:0]    cnt_q, cnt_d, pos_q, pos_d;
    logic [CW-1:0]    last_cnt;
    logic             en, tap, s, maj, check_acc, cmp_bad, cmp_last;

    assign en        = ~i_CLK2M_PCEN_n;
    assign tap       = len_q ? acc_q[USER_TAP] : acc_q[0];
    assign s         = i_BIT ^ tap ^ carry_q;
    assign maj       = (i_BIT & tap) | (i_BIT & carry_q) | (tap & carry_q);
    assign last_cnt  = len_q ? CW'(L_USER - 1) : CW'(SUM_W - 1);
    assign check_acc = i_CHECK && (state_q == IDLE || state_q == ACCUM);
    assign cmp_bad   = tap != ref_q[cnt_q];
    assign cmp_last  = cnt_q == last_cnt;

    assign o_SUM          = acc_q;
    assign o_SUMEQ_n      = sumeq_n_q;
    assign o_MISMATCH_POS = pos_q;

    // State register, advanced only on enabled cycles
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n)
            state_q <= IDLE;
        else if (en)
            state_q <= state_d;
    end

    // Next state: START restarts from anywhere, CHECK only from IDLE/ACCUM
    always_comb begin
        state_d = state_q;
        if (i_START)
            state_d = ACCUM;
        else if (check_acc)
            state_d = CMP;
        else if (state_q == CMP && cmp_last)
            state_d = DONE;
        else if (state_q == DONE)
            state_d = IDLE;
    end

    // Status outputs decoded from state
    always_comb begin
        o_BUSY = state_q == ACCUM || state_q == CMP;
        o_DONE = state_q == DONE;
    end

    // Datapath next values: accumulate, rotate-and-compare, reference load
    always_comb begin
        acc_d     = acc_q;
        carry_d   = carry_q;
        ref_d     = ref_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        pos_d     = pos_q;
        sumeq_n_d = sumeq_n_q;
        if (i_START) begin
            acc_d     = '0;
            carry_d   = 1'b0;
            len_d     = i_LEN_SEL;
            cnt_d     = '0;
            miss_d    = 1'b0;
            pos_d     = '0;
            sumeq_n_d = 1'b1;
        end else if (check_acc) begin
            cnt_d  = '0;
            miss_d = 1'b0;
            pos_d  = '0;
        end else begin
            if (i_REF_LD && state_q != CMP)
                ref_d = i_REF;
            if (state_q == ACCUM) begin
                if (i_BIT_VLD)
                    acc_d = {s, acc_q[SUM_W-1:1]};
                // Clear applies to the stored carry only; XOR mode never keeps a carry
                carry_d = i_BIT_VLD ? (maj & ~i_CARRY_CLR & ~i_MODE) : (carry_q & ~i_CARRY_CLR);
            end
            if (state_q == CMP) begin
                acc_d = {tap, acc_q[SUM_W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cmp_bad && !miss_q) begin
                    miss_d = 1'b1;
                    pos_d  = cnt_q;
                end
                if (cmp_last)
                    sumeq_n_d = miss_q | cmp_bad;
            end
        end
    end

    // Datapath registers, updated only on enabled cycles
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            acc_q     <= '0;
            carry_q   <= 1'b0;
            ref_q     <= '0;
            len_q     <= 1'b0;
            cnt_q     <= '0;
            miss_q    <= 1'b0;
            pos_q     <= '0;
            sumeq_n_q <= 1'b1;
        end else if (en) begin
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            ref_q     <= ref_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            pos_q     <= pos_d;
            sumeq_n_q <= sumeq_n_d;
        end
    end
endmodule

// File: tb/tb_k005297_sumcmp_gen.sv
// tb_k005297_sumcmp_gen: directed and randomized checks of the serial checksum/compare unit.
module tb_k005297_sumcmp_gen;
    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcen_n = 1'b0;
    logic        start = 1'b0, mode = 1'b0, len_sel = 1'b0;
    logic        bit_vld = 1'b0, bit_i = 1'b0, carry_clr = 1'b0;
    logic        ref_ld = 1'b0, check = 1'b0;
    logic [11:0] ref_in = '0;
    logic        busy, done, sumeq_n;
    logic [11:0] sum;
    logic [3:0]  mpos;
    int          checks = 0;
    int          failures = 0;

    k005297_sumcmp_gen #(.SUM_W(12), .USER_TAP(4)) dut (
        .i_MCLK(mclk), .i_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n),
        .i_START(start), .i_MODE(mode), .i_LEN_SEL(len_sel),
        .i_BIT_VLD(bit_vld), .i_BIT(bit_i), .i_CARRY_CLR(carry_clr),
        .i_REF_LD(ref_ld), .i_REF(ref_in), .i_CHECK(check),
        .o_BUSY(busy), .o_DONE(done), .o_SUMEQ_n(sumeq_n),
        .o_SUM(sum), .o_MISMATCH_POS(mpos)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic ls);
        mode = m; len_sel = ls; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Serial word, LSB first, carry cleared on the last bit, with random idle/disabled gaps
    task automatic send_word(input logic [11:0] w, input int nb);
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                bit_vld = 1'b0; carry_clr = 1'b0; bit_i = $urandom_range(0, 1);
                pcen_n = $urandom_range(0, 1);
                cyc();
                pcen_n = 1'b0;
            end
            bit_vld = 1'b1; bit_i = w[b]; carry_clr = (b == nb - 1);
            cyc();
        end
        bit_vld = 1'b0; carry_clr = 1'b0;
    endtask

    // Load reference, start compare, count enabled cycles to DONE and check the verdict
    task automatic run_check(input string tag, input logic [11:0] r, input int l,
                             input logic exp_neq, input int exp_pos);
        int n;
        int waited;
        logic seen;
        ref_in = r; ref_ld = 1'b1;
        cyc();
        ref_ld = 1'b0; check = 1'b1;
        cyc();
        check = 1'b0;
        n = 0; waited = 0; seen = 1'b0;
        while (!seen && waited < 80) begin
            pcen_n = ($urandom_range(0, 3) == 0);
            cyc();
            if (!pcen_n) n++;
            waited++;
            seen = done;
        end
        pcen_n = 1'b0;
        chk({tag, "_lat"}, seen ? n : 999, l);
        chk({tag, "_sumeq_n"}, sumeq_n, exp_neq);
        chk({tag, "_pos"}, mpos, exp_pos);
        chk({tag, "_busy"}, busy, 0);
        cyc();
        chk({tag, "_done_off"}, done, 0);
    endtask

    initial begin
        logic [11:0] s0;
        repeat (2) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sumeq_n", sumeq_n, 1);
        chk("rst_sum", sum, 0);
        chk("rst_pos", mpos, 0);
        rst_n = 1'b1;
        cyc();

        do_start(0, 0);
        chk("start_busy", busy, 1);
        send_word(12'h123, 12); send_word(12'h456, 12);
        chk("add_sum", sum, 12'h579);
        run_check("add_eq", 12'h579, 12, 0, 0);
        chk("add_realign", sum, 12'h579);

        do_start(0, 0);
        send_word(12'h123, 12); send_word(12'h456, 12);
        run_check("add_ne", 12'h571, 12, 1, 3);

        do_start(0, 0);
        send_word(12'hFFF, 12); send_word(12'h001, 12);
        chk("add_wrap", sum, 12'h000);

        do_start(1, 0);
        send_word(12'hFFF, 12); send_word(12'h0F0, 12);
        chk("xor_sum", sum, 12'hF0F);
        run_check("xor_eq", 12'hF0F, 12, 0, 0);

        do_start(0, 1);
        send_word(12'h0AB, 8); send_word(12'h011, 8);
        chk("usr_sum", sum[11:4], 8'hBC);
        run_check("usr_eq", 12'h0BC, 8, 0, 0);
        run_check("usr_hi_ign", 12'hFBC, 8, 0, 0);
        run_check("usr_ne", 12'h0B8, 8, 1, 2);

        do_start(0, 0);
        send_word(12'h0C5, 6);
        s0 = sum;
        pcen_n = 1'b1; bit_vld = 1'b1; bit_i = 1'b1; carry_clr = 1'b1;
        repeat (5) cyc();
        chk("pcen_sum", sum, s0);
        chk("pcen_busy", busy, 1);
        pcen_n = 1'b0; bit_vld = 1'b0; carry_clr = 1'b0;

        do_start(0, 0);
        send_word(12'h3A5, 12);
        ref_in = 12'h3A5; ref_ld = 1'b1; cyc(); ref_ld = 1'b0;
        check = 1'b1; cyc(); check = 1'b0;
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sumeq_n", sumeq_n, 1);
        chk("arst_sum", sum, 0);
        chk("arst_pos", mpos, 0);
        #1 rst_n = 1'b1;
        cyc();

        do_start(0, 0);
        send_word(12'h123, 12); send_word(12'h456, 12);
        run_check("abort_pre", 12'h579, 12, 0, 0);
        check = 1'b1; cyc(); check = 1'b0;
        repeat (5) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        chk("abort_busy", busy, 1);
        chk("abort_sum", sum, 0);
        chk("abort_sumeq_n", sumeq_n, 1);
        begin
            int dn;
            dn = 0;
            repeat (15) begin cyc(); if (done) dn++; end
            chk("abort_nodone", dn, 0);
        end
        chk("abort_busy2", busy, 1);

        for (int it = 0; it < 30; it++) begin
            logic m, ls;
            logic [11:0] eff, w, r, mask, diff;
            int l, nw, pos;
            m = $urandom_range(0, 1);
            ls = $urandom_range(0, 1);
            l = ls ? 8 : 12;
            mask = ls ? 12'h0FF : 12'hFFF;
            do_start(m, ls);
            eff = '0;
            nw = $urandom_range(1, 4);
            for (int j = 0; j < nw; j++) begin
                w = 12'($urandom) & mask;
                send_word(w, l);
                eff = m ? (eff ^ w) : ((eff + w) & mask);
            end
            chk("rnd_sum", ls ? {4'h0, sum[11:4]} : sum, eff);
            diff = $urandom_range(0, 1) ? 12'h000 : (12'($urandom) & mask);
            r = eff ^ diff;
            if (ls) r[11:8] = 4'($urandom);
            pos = 0;
            for (int k = l - 1; k >= 0; k--) if (diff[k]) pos = k;
            run_check("rnd", r, l, diff != 0, pos);
            chk("rnd_realign", ls ? {4'h0, sum[11:4]} : sum, eff);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
